// File: rtl/ibex_shadow_stack_ctrl_if.sv
// Request bus from the shadow-stack controller (master) to the shadow stack (slave).
// The stack answers each strobe with a same-cycle error flag.
interface ibex_shadow_stack_ctrl_if;
  logic [31:0] ss_pointer_wr;
  logic        ss_write;
  logic [31:0] ss_pointer_rd;
  logic        ss_read;
  logic        ss_error;

  modport master (
    output ss_pointer_wr, ss_write, ss_pointer_rd, ss_read,
    input  ss_error
  );

  modport slave (
    input  ss_pointer_wr, ss_write, ss_pointer_rd, ss_read,
    output ss_error
  );
endinterface

// File: rtl/ibex_shadow_stack_ctrl.sv
// Decodes retiring calls/returns into shadow-stack push/pop ops, queues them in a small FIFO,
// issues one op per cycle to the stack and latches a sticky alert on stack error or queue overflow.
module ibex_shadow_stack_ctrl #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic        ENABLE_RST  = 1'b0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             cfg_en_i,
  input  logic                             cfg_en_val_i,
  input  logic                             clear_alert_i,
  input  logic                             instr_valid_i,
  input  logic [31:0]                      instr_i,
  input  logic                             instr_is_c_i,
  input  logic [31:0]                      pc_i,
  input  logic [31:0]                      jump_target_i,
  output logic                             stall_o,
  ibex_shadow_stack_ctrl_if.master         ss,
  output logic                             alert_o,
  output logic [1:0]                       alert_cause_o,
  output logic [31:0]                      alert_pc_o
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_POP  = 2'b01;
  localparam logic [1:0] CAUSE_PUSH = 2'b10;
  localparam logic [1:0] CAUSE_OVF  = 2'b11;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ALERT} state_e;
  typedef enum logic {OP_PUSH = 1'b0, OP_POP = 1'b1} op_e;

  typedef struct packed {
    op_e         op;
    logic [31:0] value;
    logic [31:0] pc;
  } entry_t;

  state_e        state_q, state_d;
  logic          enable_q, enable_d;
  logic          alert_q, alert_d;
  logic [1:0]    cause_q, cause_d;
  logic [31:0]   alert_pc_q, alert_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [QUEUE_DEPTH];

  entry_t        head, entry0, entry1;
  logic          we0, we1;
  logic [1:0]    n_enq;
  logic          issue, stack_err, overflow, decode_active, accept;
  logic          is_jal, is_jalr, rd_link, rs1_link, dec_push, dec_pop;
  logic [4:0]    rd_idx, rs1_idx;
  logic [31:0]   link_addr;

  // Immediate bits are irrelevant to the call/return classification.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_i[31:20];

  // ---------------------------------------------------------------------------
  // Decode: x1 and x5 are the link registers
  // ---------------------------------------------------------------------------
  assign rd_idx    = instr_i[11:7];
  assign rs1_idx   = instr_i[19:15];
  assign is_jal    = (instr_i[6:0] == OPC_JAL);
  assign is_jalr   = (instr_i[6:0] == OPC_JALR) && (instr_i[14:12] == 3'b000);
  assign rd_link   = (rd_idx == 5'd1) || (rd_idx == 5'd5);
  assign rs1_link  = (rs1_idx == 5'd1) || (rs1_idx == 5'd5);
  assign link_addr = pc_i + (instr_is_c_i ? 32'd2 : 32'd4);

  always_comb begin
    dec_push = 1'b0;
    dec_pop  = 1'b0;
    if (is_jal) begin
      dec_push = rd_link;
    end else if (is_jalr) begin
      dec_push = rd_link;
      dec_pop  = rs1_link && (!rd_link || (rd_idx != rs1_idx));
    end
  end

  // ---------------------------------------------------------------------------
  // Issue side: head of the queue drives the stack directly
  // ---------------------------------------------------------------------------
  assign head      = mem_q[rd_ptr_q];
  assign issue     = (state_q != ST_ALERT) && (count_q != '0);
  assign stack_err = issue && ss.ss_error;

  assign ss.ss_write      = issue && (head.op == OP_PUSH);
  assign ss.ss_read       = issue && (head.op == OP_POP);
  assign ss.ss_pointer_wr = (issue && (head.op == OP_PUSH)) ? head.value : '0;
  assign ss.ss_pointer_rd = (issue && (head.op == OP_POP))  ? head.value : '0;

  // A POP+PUSH instr needs two free entries, so stall below that.
  assign stall_o       = (count_q > CW'(QUEUE_DEPTH - 2));
  assign decode_active = enable_q && (state_q == ST_RUN);
  assign overflow      = instr_valid_i && stall_o && (state_q != ST_ALERT);
  assign accept        = instr_valid_i && decode_active && !stall_o;

  // ---------------------------------------------------------------------------
  // Enqueue: POP always lands before PUSH so order is preserved
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    we0    = 1'b0;
    we1    = 1'b0;
    n_enq  = 2'd0;
    entry0 = '{op: OP_POP,  value: jump_target_i, pc: pc_i};
    entry1 = '{op: OP_PUSH, value: link_addr,     pc: pc_i};
    if (accept) begin
      if (dec_pop) begin
        we0   = 1'b1;
        we1   = dec_push;
        n_enq = dec_push ? 2'd2 : 2'd1;
      end else if (dec_push) begin
        entry0 = entry1;
        we0    = 1'b1;
        n_enq  = 2'd1;
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(issue);
    wr_ptr_d = wr_ptr_q + AW'(n_enq);
    count_d  = count_q + CW'(n_enq) - CW'(issue);
    if (state_q == ST_ALERT) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and sticky alert
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    enable_d   = enable_q;
    alert_d    = alert_q;
    cause_d    = cause_q;
    alert_pc_d = alert_pc_q;
    if (cfg_en_i) begin
      enable_d = cfg_en_val_i;
    end
    unique case (state_q)
      ST_RUN, ST_DRAIN: begin
        if (stack_err) begin
          state_d    = ST_ALERT;
          alert_d    = 1'b1;
          cause_d    = (head.op == OP_POP) ? CAUSE_POP : CAUSE_PUSH;
          alert_pc_d = head.pc;
        end else if (overflow) begin
          state_d    = ST_ALERT;
          alert_d    = 1'b1;
          cause_d    = CAUSE_OVF;
          alert_pc_d = pc_i;
        end else if ((state_q == ST_RUN) && cfg_en_i && !cfg_en_val_i && (count_q != '0)) begin
          state_d = ST_DRAIN;
        end else if ((state_q == ST_DRAIN) && (count_q == '0)) begin
          state_d = ST_RUN;
        end
      end
      ST_ALERT: begin
        if (clear_alert_i) begin
          state_d    = ST_RUN;
          alert_d    = 1'b0;
          cause_d    = CAUSE_NONE;
          alert_pc_d = '0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      enable_q   <= ENABLE_RST;
      alert_q    <= 1'b0;
      cause_q    <= CAUSE_NONE;
      alert_pc_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      alert_q    <= alert_d;
      cause_q    <= cause_d;
      alert_pc_q <= alert_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: queue storage has no reset; occupancy gates every read, so stale entries are never seen.
  always_ff @(posedge clk_i) begin
    if (we0) begin
      mem_q[wr_ptr_q] <= entry0;
    end
    if (we1) begin
      mem_q[wr_ptr_q + AW'(1)] <= entry1;
    end
  end

  assign alert_o       = alert_q;
  assign alert_cause_o = cause_q;
  assign alert_pc_o    = alert_pc_q;

endmodule
